ahb_sram_slave: RTL and testbench

AHB-Lite memory slave placed directly downstream of the AHB-Lite master on the same bus. It decodes address phases from the master, stores and returns data from an internal word-organised RAM, and drives `Hready`, `Hresp` and `HRdata` back. It supports a configurable number of wait states and gives a two-cycle ERROR response on illegal accesses.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_byte_strobe.sv | 29 ++
 rtl/ahb_sram_slave.sv | 140 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane decode for one AHB beat, with alignment check.
module ahb_byte_strobe (
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strobe,
  output logic       o_misaligned
);
  import ahb_pkg::*;

  // Map transfer size and low address bits to lane enables.
  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_strobe     = 4'b0000;
    o_misaligned = 1'b0;
    case (i_size)
      HSIZE_BYTE: o_strobe = 4'b0001 << i_addr_lo;
      HSIZE_HALF: begin
        o_strobe     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addr_lo[0];
      end
      HSIZE_WORD: begin
        o_strobe     = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with configurable wait states and
// two-cycle ERROR response for illegal beats.
module ahb_sram_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        Hresetn,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] HWdata,
  input  logic        Hready_in,
  output logic        Hready,
  output logic        Hresp,
  output logic [31:0] HRdata
);
  import ahb_pkg::*;

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e          r_state, w_state_nxt;
  logic [3:0]            r_wait_cnt, w_wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [3:0]            r_strobe;
  logic                  r_write;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic [31:0]           w_offset;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_strobe;
  logic                  w_misaligned;
  logic                  w_illegal;
  logic                  w_addr_slot;
  logic                  w_accept;
  logic                  w_commit;
  logic [31:0]           w_fwd_word;
  logic                  w_unused;

  // Burst type and the BUSY/IDLE distinction carry no meaning here.
  assign w_unused = ^{Hburst, Htrans[0]};

  assign w_offset = Haddr - BASE_ADDR;
  assign w_idx    = w_offset[ADDR_WIDTH+1:2];

  ahb_byte_strobe u_strobe (
    .i_size       (Hsize),
    .i_addr_lo    (w_offset[1:0]),
    .o_strobe     (w_strobe),
    .o_misaligned (w_misaligned)
  );

  // An address below the base wraps to a huge offset and is rejected as out of range.
  assign w_illegal   = (Hsize > HSIZE_WORD) | w_misaligned | (|w_offset[31:ADDR_WIDTH+2]);
  assign w_addr_slot = (r_state != ST_WAIT) && (r_state != ST_ERR1);
  assign w_accept    = Hsel & Hready_in & Htrans[1] & w_addr_slot;
  assign w_commit    = (r_state == ST_DONE) & r_write;

  // Next-state, wait counter and response outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    Hready         = 1'b1;
    Hresp          = HRESP_OKAY;
    case (r_state)
      ST_WAIT: begin
        Hready = 1'b0;
        if (r_wait_cnt == 4'd0) w_state_nxt = ST_DONE;
        else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      ST_ERR1: begin
        Hready      = 1'b0;
        Hresp       = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: begin
        if (r_state == ST_ERR2) Hresp = HRESP_ERROR;
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = WAIT_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
    endcase
  end

  // State register and captured address-phase controls.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_strobe   <= 4'b0000;
      r_write    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_idx    <= w_idx;
        r_strobe <= w_strobe;
        r_write  <= Hwrite;
      end
    end
  end

  // Read word for a new address phase, merging lanes of a write committing this same cycle.
  always_comb begin
    w_fwd_word = r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_commit && (r_idx == w_idx) && r_strobe[b]) w_fwd_word[8*b +: 8] = HWdata[8*b +: 8];
    end
  end

  // RAM write port (strobed, on the final data-phase cycle) and synchronous read capture.
  // NOTE: the RAM array and its read register are deliberately not reset; the state machine gates their use.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strobe[b]) r_mem[r_idx][8*b +: 8] <= HWdata[8*b +: 8];
      end
    end
    if (w_accept && !w_illegal && !Hwrite) r_rdata <= w_fwd_word;
  end

  assign HRdata = ((r_state == ST_DONE) && !r_write) ? r_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) on a shared bus,
// a transaction-level reference model checked every cycle, plus directed literals.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int WS_B  = 3;
  localparam int LIMIT = 100;

  typedef struct {
    bit         ready;
    bit         resp;
    bit         rd_final;
    bit         wr_final;
    int         idx;
    logic [3:0] strb;
  } exp_t;

  typedef struct {
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        Hresetn = 1'b1;
  logic        Hsel_a = 1'b0, Hsel_b = 1'b0;
  logic [31:0] Haddr = '0, HWdata = '0;
  logic [1:0]  Htrans = HTRANS_IDLE;
  logic        Hwrite = 1'b0;
  logic [2:0]  Hsize = HSIZE_BYTE, Hburst = 3'b000;
  logic        hr_ovr_en = 1'b0, hr_ovr = 1'b1, tgt = 1'b0;
  logic        Hready_in;
  logic        Hready_a, Hresp_a, Hready_b, Hresp_b;
  logic [31:0] HRdata_a, HRdata_b;

  int n_vec = 0;
  int n_miss = 0;

  exp_t        m_q [2][$];
  exp_t        m_cur [2];
  logic [31:0] m_data [2];
  logic [31:0] m_mem [2][1024];

  beat_t       beats[$];
  logic [31:0] res_rdata [16];
  logic        res_resp [16];
  int          res_waits [16];

  always #5 clk = ~clk;

  assign Hready_in = hr_ovr_en ? hr_ovr : (tgt ? Hready_b : Hready_a);

  ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_a (
    .clk(clk), .Hresetn(Hresetn), .Hsel(Hsel_a), .Haddr(Haddr), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata),
    .Hready_in(Hready_in), .Hready(Hready_a), .Hresp(Hresp_a), .HRdata(HRdata_a)
  );

  ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(WS_B)) u_dut_b (
    .clk(clk), .Hresetn(Hresetn), .Hsel(Hsel_b), .Haddr(Haddr), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata),
    .Hready_in(Hready_in), .Hready(Hready_b), .Hresp(Hresp_b), .HRdata(HRdata_b)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(bit r, bit rs, bit rf, bit wf, int idx, logic [3:0] s);
    exp_t e;
    e.ready = r; e.resp = rs; e.rd_final = rf; e.wr_final = wf; e.idx = idx; e.strb = s;
    return e;
  endfunction

  function automatic bit spec_illegal(logic [31:0] addr, logic [2:0] size);
    return (size > 3'd2) || (size == 3'd1 && addr[0]) ||
           (size == 3'd2 && addr[1:0] != 2'b00) || ((addr - 32'h0) >= 32'(4 * 1024));
  endfunction

  function automatic logic [3:0] spec_strobe(logic [31:0] addr, logic [2:0] size);
    logic [3:0] one;
    one = 4'b0001;
    case (size)
      3'd0:    return one << addr[1:0];
      3'd1:    return addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Advance one slave's reference at a clock edge using the bus values of the ending cycle.
  task automatic model_edge(input int d);
    bit model_hr;
    bit sel;
    int ws;
    model_hr = hr_ovr_en ? hr_ovr : m_cur[tgt].ready;
    sel = (d == 1) ? Hsel_b : Hsel_a;
    ws  = (d == 1) ? WS_B : 0;
    if (!Hresetn) begin
      m_q[d].delete();
      m_cur[d]  = mk(1, 0, 0, 0, 0, 4'b0);
      m_data[d] = '0;
    end else begin
      if (m_cur[d].wr_final) begin
        for (int b = 0; b < 4; b++)
          if (m_cur[d].strb[b]) m_mem[d][m_cur[d].idx][8*b +: 8] = HWdata[8*b +: 8];
      end
      if (m_cur[d].ready && sel && model_hr && Htrans[1]) begin
        if (spec_illegal(Haddr, Hsize)) begin
          m_q[d].push_back(mk(0, 1, 0, 0, 0, 4'b0));
          m_q[d].push_back(mk(1, 1, 0, 0, 0, 4'b0));
        end else begin
          repeat (ws) m_q[d].push_back(mk(0, 0, 0, 0, 0, 4'b0));
          m_q[d].push_back(mk(1, 0, !Hwrite, Hwrite, int'(Haddr >> 2), spec_strobe(Haddr, Hsize)));
        end
      end
      m_cur[d]  = (m_q[d].size() > 0) ? m_q[d].pop_front() : mk(1, 0, 0, 0, 0, 4'b0);
      m_data[d] = m_cur[d].rd_final ? m_mem[d][m_cur[d].idx] : 32'h0;
    end
  endtask

  // Reference update on each edge, then compare both slaves shortly after it.
  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    #1;
    check("cycle_a", {Hready_a, Hresp_a, HRdata_a}, {m_cur[0].ready, m_cur[0].resp, m_data[0]});
    check("cycle_b", {Hready_b, Hresp_b, HRdata_b}, {m_cur[1].ready, m_cur[1].resp, m_data[1]});
  end

  task automatic drive_idle();
    Hsel_a = 1'b0; Hsel_b = 1'b0; Htrans = HTRANS_IDLE;
    Hwrite = 1'b0; Haddr = '0; Hsize = HSIZE_BYTE;
  endtask

  task automatic add(input logic [1:0] t, input bit w, input logic [31:0] a,
                     input logic [2:0] s, input logic [31:0] wd);
    beat_t bt;
    bt.trans = t; bt.write = w; bt.addr = a; bt.size = s; bt.wdata = wd;
    beats.push_back(bt);
  endtask

  // Pipelined master: issue queued beats to slave d, recording per-beat results.
  task automatic run(input bit d);
    int k, dp, n, cyc;
    k = 0; dp = -1; n = beats.size(); cyc = 0;
    for (int i = 0; i < 16; i++) res_waits[i] = 0;
    tgt = d;
    @(negedge clk);
    while ((k < n || dp >= 0) && cyc < LIMIT) begin
      if (dp >= 0) HWdata = beats[dp].wdata;
      if (Hready_in) begin
        if (dp >= 0) begin
          res_rdata[dp] = d ? HRdata_b : HRdata_a;
          res_resp[dp]  = d ? Hresp_b : Hresp_a;
        end
        if (k < n) begin
          Hsel_a = !d; Hsel_b = d;
          Htrans = beats[k].trans; Hwrite = beats[k].write;
          Haddr  = beats[k].addr;  Hsize  = beats[k].size;
          dp = k; k++;
        end else begin
          drive_idle();
          dp = -1;
        end
      end else if (dp >= 0) begin
        res_waits[dp]++;
      end
      @(negedge clk);
      cyc++;
    end
    check("drv_budget_expired", cyc >= LIMIT, 0);
    beats.delete();
  endtask

  initial begin
    #3 Hresetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hready_a", Hready_a, 1);
    check("rst_hresp_a", Hresp_a, 0);
    check("rst_hrdata_a", HRdata_a, 0);
    check("rst_hready_b", Hready_b, 1);
    check("rst_hresp_b", Hresp_b, 0);
    check("rst_hrdata_b", HRdata_b, 0);
    Hresetn = 1'b1;

    // Back-to-back write then read of the same word (forwarding).
    add(HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    add(HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);
    run(0);
    check("t1_rdata", res_rdata[1], 32'hDEADBEEF);
    check("t1_resp", res_resp[1], 0);
    check("t1_waits", res_waits[1], 0);

    // Byte and half writes into a zeroed word.
    add(HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'h0);
    add(HTRANS_NONSEQ, 1, 32'h13, HSIZE_BYTE, 32'hA500_0000);
    add(HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);
    add(HTRANS_NONSEQ, 1, 32'h12, HSIZE_HALF, 32'h1234_0000);
    add(HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);
    run(0);
    check("t2_byte_rd", res_rdata[2], 32'hA500_0000);
    check("t2_half_rd", res_rdata[4], 32'h1234_0000);
    check("t2_model_word", m_mem[0][4], 32'h1234_0000);

    // Illegal beats: misaligned word, out of range, oversize; memory untouched.
    add(HTRANS_NONSEQ, 1, 32'h00, HSIZE_WORD, 32'hCAFEF00D);
    add(HTRANS_NONSEQ, 1, 32'h04, HSIZE_WORD, 32'h0BADC0DE);
    add(HTRANS_NONSEQ, 1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF);
    add(HTRANS_NONSEQ, 1, 32'h1000, HSIZE_WORD, 32'hFFFFFFFF);
    add(HTRANS_NONSEQ, 1, 32'h04, 3'b011, 32'hFFFFFFFF);
    add(HTRANS_NONSEQ, 0, 32'h00, HSIZE_WORD, 32'h0);
    add(HTRANS_NONSEQ, 0, 32'h04, HSIZE_WORD, 32'h0);
    run(0);
    check("t3_misalign_resp", res_resp[2], 1);
    check("t3_misalign_waits", res_waits[2], 1);
    check("t3_range_resp", res_resp[3], 1);
    check("t3_size_resp", res_resp[4], 1);
    check("t3_rd0", res_rdata[5], 32'hCAFEF00D);
    check("t3_rd4", res_rdata[6], 32'h0BADC0DE);

    // BUSY inside an INCR burst has no effect.
    add(HTRANS_NONSEQ, 1, 32'h30, HSIZE_WORD, 32'h0102_0304);
    add(HTRANS_BUSY,   1, 32'h34, HSIZE_WORD, 32'hFFFF_FFFF);
    add(HTRANS_SEQ,    1, 32'h34, HSIZE_WORD, 32'h0506_0708);
    run(0);
    check("t4_busy_resp", res_resp[1], 0);
    check("t4_busy_waits", res_waits[1], 0);

    // NONSEQ with bus HREADY low is ignored.
    hr_ovr_en = 1'b1; hr_ovr = 1'b0; tgt = 1'b0;
    Hsel_a = 1'b1; Htrans = HTRANS_NONSEQ; Hwrite = 1'b1; Haddr = 32'h30; Hsize = HSIZE_WORD;
    @(negedge clk);
    HWdata = 32'hDEAD_0000;
    drive_idle();
    hr_ovr_en = 1'b0;
    check("t4_ovr_ready", Hready_a, 1);
    check("t4_ovr_resp", Hresp_a, 0);
    add(HTRANS_NONSEQ, 0, 32'h30, HSIZE_WORD, 32'h0);
    add(HTRANS_NONSEQ, 0, 32'h34, HSIZE_WORD, 32'h0);
    run(0);
    check("t4_rd30", res_rdata[0], 32'h0102_0304);
    check("t4_rd34", res_rdata[1], 32'h0506_0708);

    // Three wait states on the second slave.
    add(HTRANS_NONSEQ, 1, 32'h40, HSIZE_WORD, 32'h55AA_55AA);
    add(HTRANS_NONSEQ, 0, 32'h40, HSIZE_WORD, 32'h0);
    run(1);
    check("t5_wr_waits", res_waits[0], 3);
    check("t5_rd_waits", res_waits[1], 3);
    check("t5_rdata", res_rdata[1], 32'h55AA_55AA);

    // Reset during the wait phase of a write drops the write.
    tgt = 1'b1;
    Hsel_b = 1'b1; Htrans = HTRANS_NONSEQ; Hwrite = 1'b1; Haddr = 32'h40; Hsize = HSIZE_WORD;
    @(negedge clk);
    drive_idle();
    HWdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t6_in_wait", Hready_b, 0);
    Hresetn = 1'b0;
    #1;
    check("t6_rst_ready", Hready_b, 1);
    check("t6_rst_resp", Hresp_b, 0);
    check("t6_rst_rdata", HRdata_b, 0);
    @(negedge clk);
    Hresetn = 1'b1;
    add(HTRANS_NONSEQ, 0, 32'h40, HSIZE_WORD, 32'h0);
    run(1);
    check("t6_rd40", res_rdata[0], 32'h55AA_55AA);
    add(HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);
    run(0);
    check("t6_ram_kept", res_rdata[0], 32'h1234_0000);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
